// File: rtl/nts_api_bridge_if.sv
// Host-side request/response stream plus the decoder-side API bus of nts_api_bridge.
// The master modport is the host/decoder side; the slave modport is the bridge.
interface nts_api_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [11:0] req_address;
  logic [31:0] req_write_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_read_data;
  logic        api_cs;
  logic        api_we;
  logic [11:0] api_address;
  logic [31:0] api_write_data;
  logic [31:0] api_read_data;

  modport master (
    output req_valid, req_we, req_address, req_write_data, rsp_ready, api_read_data,
    input  req_ready, rsp_valid, rsp_write, rsp_read_data,
    input  api_cs, api_we, api_address, api_write_data
  );

  modport slave (
    input  req_valid, req_we, req_address, req_write_data, rsp_ready, api_read_data,
    output req_ready, rsp_valid, rsp_write, rsp_read_data,
    output api_cs, api_we, api_address, api_write_data
  );
endinterface

// File: rtl/nts_api_bridge.sv
// Single-outstanding bridge from a valid/ready request stream to the NTS API
// cs/we bus; reads hold cs for READ_LATENCY+1 cycles, writes strobe cs once.
module nts_api_bridge #(
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic              i_clk,
  input  logic              i_areset,
  nts_api_bridge_if.slave   bus,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = (READ_LATENCY > 32'd0) ? 3'(READ_LATENCY - 32'd1) : 3'd0;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        hold_we_q, hold_we_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  // Next-state and next-output decode for the transaction FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_we_d   = hold_we_q;
    cs_d        = cs_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d   = ISSUE;
          hold_we_d = bus.req_we;
          cs_d      = 1'b1;
          we_d      = bus.req_we;
          addr_d    = bus.req_address;
          wdata_d   = bus.req_write_data;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (hold_we_q) begin
          state_d     = RESP;
          cs_d        = 1'b0;
          we_d        = 1'b0;
          addr_d      = 12'd0;
          wdata_d     = 32'd0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_data_d  = 32'd0;
        end else if (READ_LATENCY == 32'd0) begin
          state_d     = RESP;
          cs_d        = 1'b0;
          we_d        = 1'b0;
          addr_d      = 12'd0;
          wdata_d     = 32'd0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_data_d  = bus.api_read_data;
        end else begin
          // Address and cs stay driven; the decoder needs a stable read window
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          we_d    = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d     = RESP;
          cs_d        = 1'b0;
          we_d        = 1'b0;
          addr_d      = 12'd0;
          wdata_d     = 32'd0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_data_d  = bus.api_read_data;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_write_d = 1'b0;
          rsp_data_d  = 32'd0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 3'd0;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        addr_d      = 12'd0;
        wdata_d     = 32'd0;
        rsp_valid_d = 1'b0;
        rsp_write_d = 1'b0;
        rsp_data_d  = 32'd0;
      end
    endcase
  end

  // State, holding and output registers; reset aborts any transaction in flight
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      hold_we_q   <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 12'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_we_q   <= hold_we_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign o_busy             = (state_q != IDLE);
  assign bus.api_cs         = cs_q;
  assign bus.api_we         = we_q;
  assign bus.api_address    = addr_q;
  assign bus.api_write_data = wdata_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_write      = rsp_write_q;
  assign bus.rsp_read_data  = rsp_data_q;
endmodule

// File: tb/tb_nts_api_bridge.sv
// Directed scoreboard bench for nts_api_bridge with READ_LATENCY 0, 2 and 3 instances;
// sel chooses which instance the shared stimulus and observation signals address.
module tb_nts_api_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [11:0] req_address;
  logic [31:0] req_write_data, rd_early, rd_late, api_rd;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  logic        busy0, busy2, busy3;
  logic        m_req_ready, m_rsp_valid, m_rsp_write, m_cs, m_we, m_busy;
  logic [11:0] m_addr;
  logic [31:0] m_rsp_data, m_wdata;

  int          cs_run = 0;
  int          cs_total = 0, we_total = 0, zero_viol = 0;
  logic [11:0] last_addr = 12'd0;
  logic [31:0] last_wdata = 32'd0;
  int          cs_start, we_start;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cs_len;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  nts_api_bridge_if if0();
  nts_api_bridge_if if2();
  nts_api_bridge_if if3();

  nts_api_bridge #(.READ_LATENCY(0)) dut0 (.i_clk(clk), .i_areset(rst), .bus(if0), .o_busy(busy0));
  nts_api_bridge #(.READ_LATENCY(2)) dut2 (.i_clk(clk), .i_areset(rst), .bus(if2), .o_busy(busy2));
  nts_api_bridge #(.READ_LATENCY(3)) dut3 (.i_clk(clk), .i_areset(rst), .bus(if3), .o_busy(busy3));

  assign if0.req_valid = req_valid && (sel == 0);
  assign if2.req_valid = req_valid && (sel == 1);
  assign if3.req_valid = req_valid && (sel == 2);
  assign if0.rsp_ready = rsp_ready && (sel == 0);
  assign if2.rsp_ready = rsp_ready && (sel == 1);
  assign if3.rsp_ready = rsp_ready && (sel == 2);
  assign if0.req_we = req_we;  assign if0.req_address = req_address;  assign if0.req_write_data = req_write_data;
  assign if2.req_we = req_we;  assign if2.req_address = req_address;  assign if2.req_write_data = req_write_data;
  assign if3.req_we = req_we;  assign if3.req_address = req_address;  assign if3.req_write_data = req_write_data;
  assign if0.api_read_data = api_rd;
  assign if2.api_read_data = api_rd;
  assign if3.api_read_data = api_rd;

  // Decoder model: combinational data, zero outside cs, switches value from the 3rd cs cycle
  assign api_rd = m_cs ? ((cs_run >= 2) ? rd_late : rd_early) : 32'h0;

  always_comb begin
    case (sel)
      0: begin
        m_req_ready = if0.req_ready; m_rsp_valid = if0.rsp_valid; m_rsp_write = if0.rsp_write;
        m_rsp_data = if0.rsp_read_data; m_cs = if0.api_cs; m_we = if0.api_we;
        m_addr = if0.api_address; m_wdata = if0.api_write_data; m_busy = busy0;
      end
      1: begin
        m_req_ready = if2.req_ready; m_rsp_valid = if2.rsp_valid; m_rsp_write = if2.rsp_write;
        m_rsp_data = if2.rsp_read_data; m_cs = if2.api_cs; m_we = if2.api_we;
        m_addr = if2.api_address; m_wdata = if2.api_write_data; m_busy = busy2;
      end
      default: begin
        m_req_ready = if3.req_ready; m_rsp_valid = if3.rsp_valid; m_rsp_write = if3.rsp_write;
        m_rsp_data = if3.rsp_read_data; m_cs = if3.api_cs; m_we = if3.api_we;
        m_addr = if3.api_address; m_wdata = if3.api_write_data; m_busy = busy3;
      end
    endcase
  end

  always @(posedge clk) cs_run <= m_cs ? cs_run + 1 : 0;

  // Bus monitor: tallies cs/we cycles and flags any nonzero bus field while cs is low
  always @(negedge clk) begin
    if (m_cs) begin
      cs_total   <= cs_total + 1;
      we_total   <= we_total + (m_we ? 1 : 0);
      last_addr  <= m_addr;
      last_wdata <= m_wdata;
    end else if (m_we || (m_addr != 12'd0) || (m_wdata != 32'd0)) begin
      zero_viol <= zero_viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input int s);
    case (s)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic send(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input logic keep);
    exp_t e;
    int   n = 0;
    req_we = we; req_address = addr; req_write_data = wdata; req_valid = 1'b1;
    while (!m_req_ready && n < 40) begin tick(); n++; end
    chk("accept_wait", {31'd0, m_req_ready}, 32'd1);
    e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata  = we ? 32'h0 : rdata;
    e.cs_len = we ? 1 : lat_of(sel) + 1;
    sb.push_back(e);
    cs_start = cs_total; we_start = we_total;
    tick();
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic recv(input string tag);
    exp_t e;
    int   n = 0;
    while (!m_rsp_valid && n < 40) begin tick(); n++; end
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    e = sb.pop_front();
    chk({tag, "_rsp_latency"}, 32'(n), 32'(e.cs_len));
    chk({tag, "_rsp_valid"}, {31'd0, m_rsp_valid}, 32'd1);
    chk({tag, "_rsp_write"}, {31'd0, m_rsp_write}, {31'd0, e.we});
    chk({tag, "_rsp_data"}, m_rsp_data, e.rdata);
    chk({tag, "_cs_cycles"}, 32'(cs_total - cs_start), 32'(e.cs_len));
    chk({tag, "_we_cycles"}, 32'(we_total - we_start), e.we ? 32'd1 : 32'd0);
    chk({tag, "_api_addr"}, {20'd0, last_addr}, {20'd0, e.addr});
    if (e.we) chk({tag, "_api_wdata"}, last_wdata, e.wdata);
    if (rsp_ready) begin
      tick();
      chk({tag, "_busy_after"}, {31'd0, m_busy}, 32'd0);
    end
  endtask

  initial begin
    int snap;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_address = 12'd0; req_write_data = 32'd0;
    rsp_ready = 1'b1; rd_early = 32'd0; rd_late = 32'd0; sel = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_cs", {31'd0, m_cs}, 32'd0);
    chk("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    chk("rst_rsp_data", m_rsp_data, 32'd0);
    chk("rst_req_ready", {31'd0, m_req_ready}, 32'd1);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    send(1'b1, 12'h012, 32'hDEADBEEF, 32'h0, 1'b0);
    recv("wr_012");

    rd_early = 32'h12345678; rd_late = 32'h12345678;
    send(1'b0, 12'h085, 32'h0, 32'h12345678, 1'b0);
    recv("rd_085_l0");

    sel = 1; rd_early = 32'h00000001; rd_late = 32'hA5A5A5A5;
    send(1'b0, 12'h1A0, 32'h0, 32'hA5A5A5A5, 1'b0);
    recv("rd_1a0_l2");

    // Response back-pressure while another request waits
    sel = 0; rsp_ready = 1'b0; rd_early = 32'hCAFE0001; rd_late = 32'hCAFE0001;
    send(1'b0, 12'h055, 32'h0, 32'hCAFE0001, 1'b0);
    recv("rd_hold");
    req_we = 1'b1; req_address = 12'h077; req_write_data = 32'h11112222; req_valid = 1'b1;
    snap = cs_total;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rsp_valid", {31'd0, m_rsp_valid}, 32'd1);
      chk("hold_rsp_data", m_rsp_data, 32'hCAFE0001);
      chk("hold_req_ready", {31'd0, m_req_ready}, 32'd0);
    end
    chk("hold_no_cs", 32'(cs_total - snap), 32'd0);
    rsp_ready = 1'b1;
    tick();
    send(1'b1, 12'h077, 32'h11112222, 32'h0, 1'b0);
    recv("wr_after_hold");

    rd_early = 32'h10101010; rd_late = 32'h10101010;
    send(1'b1, 12'h000, 32'h0BADF00D, 32'h0, 1'b1);
    recv("b2b_wr_000");
    send(1'b0, 12'h010, 32'h0, 32'h10101010, 1'b1);
    recv("b2b_rd_010");
    send(1'b1, 12'h3FF, 32'hFFFF0000, 32'h0, 1'b0);
    recv("b2b_wr_3ff");

    // Abort a READ_LATENCY=3 read in WAIT
    sel = 2; rd_early = 32'h77777777; rd_late = 32'h77777777;
    send(1'b0, 12'h200, 32'h0, 32'h77777777, 1'b0);
    tick();
    chk("abort_cs_before", {31'd0, m_cs}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_cs_async", {31'd0, m_cs}, 32'd0);
    chk("abort_busy", {31'd0, m_busy}, 32'd0);
    sb.delete();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_rsp", {31'd0, m_rsp_valid}, 32'd0);
    end
    send(1'b1, 12'h0AB, 32'h5555AAAA, 32'h0, 1'b0);
    recv("wr_after_abort");

    chk("bus_zero_when_idle", 32'(zero_viol), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
